vga_capture: RTL and testbench
==============================

# vga_capture

Video-input capture block: the receiving end of the pixel-clock video stream our VGA timing generator produces. It samples hs/vs/de/RGB on `pclk`, finds frame and line boundaries, and decimates active pixels by 2^DEC_LOG2 in both axes. Each kept pixel is converted to RGB332 and written into the 8-bit VRAM write port at `row*STRIDE + col`. It also reports measured active width/height, frame-done pulses and a lock/error status.

## Interface
- `DEC_LOG2`, 2: log2 decimation factor, both axes (0..3).
- `STRIDE`, 160: VRAM words per row; columns >= STRIDE are clipped.
- `ROWS`, 100: VRAM rows; rows >= ROWS are clipped.
- `ADDR_W`, 14: VRAM address width.
- `HS_ACTIVE`, 0: active level of `hs`.
- `VS_ACTIVE`, 1: active level of `vs`.

- `pclk` in 1: pixel clock, the only clock.
- `rst_n` in 1: asynchronous active-low reset.
- `hs` in 1: horizontal sync.
- `vs` in 1: vertical sync.
- `de` in 1: active-video enable.
- `r`, `g`, `b` in 8 each: pixel colour.
- `enable` in 1: capture request.
- `wr_en` out 1: VRAM write strobe.
- `wr_addr` out ADDR_W: VRAM address.
- `wr_data` out 8: RGB332 pixel `{r[7:5],g[7:5],b[7:6]}`.
- `frame_done` out 1: one-cycle pulse at each frame end.
- `width` out 10: active pixels in the last line of the last frame.
- `height` out 10: active lines in the last frame.
- `locked` out 1: stable geometry detected.
- `sync_err` out 1: sticky line-length mismatch; cleared only by reset or a new `enable` rising edge.

## Operation
- Input stage: `hs`, `vs`, `de`, `r/g/b` registered once (same clock domain, no synchroniser). All edge detection uses the registered copies.
- Frame boundary: vs transition to VS_ACTIVE. Line start: de rising edge. Line end: de falling edge.
- Pixels with de high while vs is active are ignored: no writes, not counted.
- States:
  - IDLE: no writes. Leaves when `enable`=1 -> WAIT_VS.
  - WAIT_VS: waits for a frame boundary; partial frames are never captured. On the boundary -> CAPTURE, clearing x, y, row_base and the per-frame counters.
  - CAPTURE: at the next frame boundary, pulse `frame_done` and latch `width`/`height`. If `enable`=1, stay in CAPTURE and clear counters for the new frame; else -> IDLE.
  - `enable` falling mid-frame: the current frame finishes, then IDLE.
- Counters:
  - x (10 bit) counts de-high cycles in a line; it is reset at each line start.
  - y (10 bit) counts completed lines in the frame.
  - Both saturate at 1023.
- Writes:
  - Condition: CAPTURE, `x[DEC_LOG2-1:0]==0`, `y[DEC_LOG2-1:0]==0`, `col=x>>DEC_LOG2 < STRIDE`, `row=y>>DEC_LOG2 < ROWS`.
  - Address: `wr_addr = row_base + col`, truncated to ADDR_W (wraps mod 2^ADDR_W).
  - row_base += STRIDE at the end of every kept line.
- Measurement:
  - The first line of a frame sets ref_len.
  - Any later line with length != ref_len sets `sync_err` and the frame's mismatch flag.
  - A frame with no de-high line gives width=height=0, still pulses `frame_done`, and clears `locked`.
- Lock:
  - `locked` rises at the frame_done of the second consecutive frame that has identical non-zero width/height and no mismatch.
  - `locked` falls at any frame_done whose frame differs or mismatched.
  - `locked` also clears on leaving CAPTURE.

## Timing
- Reset (async assert, sync release): state IDLE; `wr_en`, `wr_addr`, `wr_data`, `frame_done`, `width`, `height`, `locked`, `sync_err` all 0.
- Latency: pixel on the inputs in cycle n -> `wr_en`/`wr_addr`/`wr_data` valid in cycle n+2, all registered, for exactly one cycle per kept pixel.
- `vs` asserting on the inputs in cycle n -> `frame_done` high in cycle n+2. `width`/`height`/`locked` update in the same cycle.
- Simultaneous frame boundary and de falling edge: line end is processed first and counts toward the ending frame.
- `rst_n` low mid-frame: immediate abort, no further writes; after release the block waits for a full new frame.

## Test plan
- 256x224 active stream (DEC_LOG2=2, hs low / vs high polarity), enable=1 for 3 frames:
  - 3584 writes per frame, first addr 0, last addr 55*160+63=8863.
  - frame_done each frame; width=256, height=224.
  - locked=1 after the second frame_done.
- 640x400 stream with DEC_LOG2=2:
  - exactly 160x100 writes; last addr 15999.
  - no clipping.
- 800x480 stream with defaults: cols >=160 and rows >=100 are never written; the write count equals 16000.
- enable raised mid-frame: zero writes until the next vs. Enable dropped mid-frame: the current frame completes, then no writes.
- Line 10 shortened to 255 pixels: sync_err=1 at line end; locked=0 at that frame_done; relock after 2 clean frames, while sync_err stays 1.
- rst_n pulsed low mid-line: outputs 0 within the same cycle; no write in the following cycles; capture resumes only after the next vs.

Source files
------------

// File: rtl/vga_capture.sv
// vga_capture: receiving end of the pixel-clock video stream. Finds frame and
// line boundaries, decimates active pixels by 2^DEC_LOG2 in both axes and
// writes kept pixels as RGB332 into an 8-bit VRAM write port at
// row*STRIDE + col. Reports measured geometry, frame-done pulses and lock /
// sync-error status.
//
// Ports:
//   pclk, rst_n        pixel clock, asynchronous active-low reset
//   hs, vs, de         sync and active-video inputs
//   r, g, b            8-bit pixel colour
//   enable             capture request
//   wr_en/addr/data    VRAM write port (registered, 2 cycles after the pixel)
//   frame_done         one-cycle pulse at each captured frame end
//   width, height      geometry of the last captured frame
//   locked             two consecutive identical clean frames seen
//   sync_err           sticky line-length mismatch
module vga_capture #(
    parameter int   DEC_LOG2  = 2,
    parameter int   STRIDE    = 160,
    parameter int   ROWS      = 100,
    parameter int   ADDR_W    = 14,
    parameter logic HS_ACTIVE = 1'b0,
    parameter logic VS_ACTIVE = 1'b1
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              hs,
    input  logic              vs,
    input  logic              de,
    input  logic [7:0]        r,
    input  logic [7:0]        g,
    input  logic [7:0]        b,
    input  logic              enable,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic [9:0]        width,
    output logic [9:0]        height,
    output logic              locked,
    output logic              sync_err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT_VS = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

    localparam logic [9:0] DMASK   = 10'((1 << DEC_LOG2) - 1);
    localparam logic [9:0] CNT_MAX = '1;

    // input stage
    logic        hs_q, vs_q, de_q;
    logic [7:0]  pix_q;
    logic        vs_d, de_v_d, en_d;

    logic [1:0]        state;
    logic [9:0]        x, y;
    logic [ADDR_W-1:0] row_base;
    logic [9:0]        ref_len, last_len;
    logic              ref_valid, mismatch;
    logic [9:0]        prev_w, prev_h;
    logic              prev_ok;

    logic       vs_act, frame_start, de_v, line_start, line_end;
    logic [9:0] x_cur, x_next, y_next, col, row;
    logic       keep_px, len_mm, mm_fin, frame_ok, lock_next;
    logic [9:0] w_fin, h_fin;

    logic unused_ok;
    assign unused_ok = ^{hs_q, HS_ACTIVE, r[4:0], g[4:0], b[5:0]};

    always_comb begin
        vs_act      = (vs_q == VS_ACTIVE);
        frame_start = vs_act && (vs_d != VS_ACTIVE);
        // de during vsync is not video: masking it here keeps those cycles
        // out of both the pixel path and the line-edge detection
        de_v        = de_q && !vs_act;
        line_start  = de_v && !de_v_d;
        line_end    = !de_v && de_v_d;
        x_cur       = line_start ? '0 : x;
        x_next      = (x_cur == CNT_MAX) ? x_cur : x_cur + 10'd1;
        y_next      = (y == CNT_MAX) ? y : y + 10'd1;
        col         = x_cur >> DEC_LOG2;
        row         = y >> DEC_LOG2;
        keep_px     = de_v && ((x_cur & DMASK) == '0) && ((y & DMASK) == '0) &&
                      (32'(col) < 32'(STRIDE)) && (32'(row) < 32'(ROWS));
        len_mm      = line_end && ref_valid && (x != ref_len);
        // a line ending in the boundary cycle still belongs to the ending frame
        w_fin       = line_end ? x : last_len;
        h_fin       = line_end ? y_next : y;
        mm_fin      = mismatch || len_mm;
        frame_ok    = (w_fin != '0) && (h_fin != '0) && !mm_fin;
        lock_next   = frame_ok && prev_ok && (w_fin == prev_w) && (h_fin == prev_h);
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q       <= !HS_ACTIVE;
            // holding vs at its active level means a reset released during
            // vsync cannot fabricate a frame boundary
            vs_q       <= VS_ACTIVE;
            vs_d       <= VS_ACTIVE;
            de_q       <= 1'b0;
            de_v_d     <= 1'b0;
            pix_q      <= '0;
            en_d       <= 1'b0;
            state      <= S_IDLE;
            x          <= '0;
            y          <= '0;
            row_base   <= '0;
            ref_len    <= '0;
            last_len   <= '0;
            ref_valid  <= 1'b0;
            mismatch   <= 1'b0;
            prev_w     <= '0;
            prev_h     <= '0;
            prev_ok    <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            width      <= '0;
            height     <= '0;
            locked     <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            hs_q   <= hs;
            vs_q   <= vs;
            de_q   <= de;
            pix_q  <= {r[7:5], g[7:5], b[7:6]};
            vs_d   <= vs_q;
            de_v_d <= de_v;
            en_d   <= enable;

            wr_en      <= 1'b0;
            frame_done <= 1'b0;

            if (enable && !en_d)
                sync_err <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (enable)
                        state <= S_WAIT_VS;
                end
                S_WAIT_VS: begin
                    if (frame_start)
                        state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (de_v)
                        x <= x_next;
                    if (keep_px) begin
                        wr_en   <= 1'b1;
                        wr_addr <= row_base + ADDR_W'(col);
                        wr_data <= pix_q;
                    end
                    if (line_end) begin
                        y        <= y_next;
                        last_len <= x;
                        if (!ref_valid) begin
                            ref_len   <= x;
                            ref_valid <= 1'b1;
                        end
                        if (len_mm) begin
                            mismatch <= 1'b1;
                            sync_err <= 1'b1;
                        end
                        if ((y & DMASK) == '0)
                            row_base <= row_base + ADDR_W'(STRIDE);
                    end
                    if (frame_start) begin
                        frame_done <= 1'b1;
                        width      <= w_fin;
                        height     <= h_fin;
                        prev_w     <= w_fin;
                        prev_h     <= h_fin;
                        if (enable) begin
                            locked  <= lock_next;
                            prev_ok <= frame_ok;
                        end else begin
                            locked  <= 1'b0;
                            prev_ok <= 1'b0;
                            state   <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase

            // new frame: placed after the line-end updates so the clear wins
            if (frame_start && (state == S_WAIT_VS || state == S_CAPTURE)) begin
                x         <= '0;
                y         <= '0;
                row_base  <= '0;
                last_len  <= '0;
                ref_len   <= '0;
                ref_valid <= 1'b0;
                mismatch  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Testbench for vga_capture: table-driven frame records with expected
// geometry/lock/error/write-count, a scoreboard of expected VRAM writes
// built from pixel coordinates, randomized frames and a mid-line reset.
module tb_vga_capture;

    localparam int DEC_LOG2 = 2;
    localparam int STRIDE   = 16;
    localparam int ROWS     = 10;
    localparam int ADDR_W   = 14;
    localparam int DEC      = 1 << DEC_LOG2;

    logic              pclk = 1'b0;
    logic              rst_n = 1'b0;
    logic              hs = 1'b1, vs = 1'b0, de = 1'b0, enable = 1'b0;
    logic [7:0]        r = '0, g = '0, b = '0;
    logic              wr_en, frame_done, locked, sync_err;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [9:0]        width, height;

    vga_capture #(
        .DEC_LOG2 (DEC_LOG2),
        .STRIDE   (STRIDE),
        .ROWS     (ROWS),
        .ADDR_W   (ADDR_W),
        .HS_ACTIVE(1'b0),
        .VS_ACTIVE(1'b1)
    ) dut (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .hs        (hs),
        .vs        (vs),
        .de        (de),
        .r         (r),
        .g         (g),
        .b         (b),
        .enable    (enable),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_done(frame_done),
        .width     (width),
        .height    (height),
        .locked    (locked),
        .sync_err  (sync_err)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        int at;
    } wr_t;

    typedef struct {
        int w; int h; int sl; int slen; bit en_mid;
        bit fd; int ew; int eh; bit lk; bit se; int nwr;
    } vec_t;

    wr_t  exp_q[$];
    vec_t tbl[15];
    int   nchk = 0, nerr = 0;
    int   wr_cnt = 0, wr_mark = 0;
    bit   cap = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // write scoreboard
    always @(negedge pclk) begin
        if (wr_en) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL spurious_write: addr=%0d data=%0d at cycle %0d, none expected",
                         wr_addr, wr_data, cyc);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", int'(wr_addr), e.addr);
                chk("wr_data", int'(wr_data), e.data);
                chk("wr_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"},      int'(wr_en), 0);
        chk({tag, "_wr_addr"},    int'(wr_addr), 0);
        chk({tag, "_wr_data"},    int'(wr_data), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_width"},      int'(width), 0);
        chk({tag, "_height"},     int'(height), 0);
        chk({tag, "_locked"},     int'(locked), 0);
        chk({tag, "_sync_err"},   int'(sync_err), 0);
    endtask

    // Drives the active part of one frame. Line sl gets length slen; enable
    // is set to en_mid at the middle line; rl/rp place a reset pulse.
    task automatic drive_active(input int w, input int h, input int sl, input int slen,
                                input bit en_mid, input int rl, input int rp);
        int rst_left = 0;
        for (int l = 0; l < h; l++) begin
            int len;
            int nb;
            if (l == h / 2) enable = en_mid;
            len = (l == sl) ? slen : w;
            for (int p = 0; p < len; p++) begin
                logic [7:0] rr, gg, bb;
                if (rst_left > 0) begin
                    rst_left--;
                    if (rst_left == 0) rst_n = 1'b1;
                end
                if (l == rl && p == rp) begin
                    rst_n = 1'b0;
                    #1;
                    chk_all_zero("midline_reset");
                    exp_q.delete();
                    cap = 1'b0;
                    rst_left = 3;
                end
                rr = 8'($urandom);
                gg = 8'($urandom);
                bb = 8'($urandom);
                de = 1'b1;
                r = rr; g = gg; b = bb;
                if (cap && (p % DEC == 0) && (l % DEC == 0) &&
                    (p / DEC < STRIDE) && (l / DEC < ROWS)) begin
                    wr_t e;
                    e.addr = ((l / DEC) * STRIDE + p / DEC) % (1 << ADDR_W);
                    e.data = int'({rr[7:5], gg[7:5], bb[7:6]});
                    e.at   = cyc + 2;
                    exp_q.push_back(e);
                end
                tick();
            end
            de = 1'b0;
            nb = $urandom_range(9, 4);
            for (int i = 0; i < nb; i++) begin
                hs = (i < 2) ? 1'b0 : 1'b1;
                tick();
            end
            hs = 1'b1;
        end
    endtask

    // Frame boundary: vs pulse, returns the results of the frame just ended.
    task automatic boundary(output bit fd, output int w, output int h,
                            output bit lk, output bit se, output int nwr);
        nwr = wr_cnt - wr_mark;
        wr_mark = wr_cnt;
        vs = 1'b1;
        de = 1'b0;
        cap = enable;
        tick();
        tick();
        fd = frame_done;
        w  = int'(width);
        h  = int'(height);
        lk = locked;
        se = sync_err;
        tick();
        chk("frame_done_one_cycle", int'(frame_done), 0);
        vs = 1'b0;
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic chk_frame(input string tag, input bit fd, input int w, input int h,
                             input bit lk, input bit se, input int nwr, input vec_t e);
        chk({tag, "_frame_done"}, int'(fd), int'(e.fd));
        chk({tag, "_width"}, w, e.ew);
        chk({tag, "_height"}, h, e.eh);
        chk({tag, "_locked"}, int'(lk), int'(e.lk));
        chk({tag, "_sync_err"}, int'(se), int'(e.se));
        chk({tag, "_writes"}, nwr, e.nwr);
    endtask

    initial begin
        bit fd, lk, se;
        int w, h, nwr;
        int pw, ph;
        bit pok;
        int rw, rh;
        vec_t e;

        //          w   h   sl slen en    fd ew  eh lk se  nwr
        tbl[0]  = '{32, 24, -1, 0, 1'b1, 1'b1, 32, 24, 1'b0, 1'b0, 48};
        tbl[1]  = '{32, 24, -1, 0, 1'b1, 1'b1, 32, 24, 1'b1, 1'b0, 48};
        tbl[2]  = '{32, 24, -1, 0, 1'b1, 1'b1, 32, 24, 1'b1, 1'b0, 48};
        tbl[3]  = '{64, 40, -1, 0, 1'b1, 1'b1, 64, 40, 1'b0, 1'b0, 160};
        tbl[4]  = '{80, 56, -1, 0, 1'b1, 1'b1, 80, 56, 1'b0, 1'b0, 160};
        tbl[5]  = '{80, 56, -1, 0, 1'b1, 1'b1, 80, 56, 1'b1, 1'b0, 160};
        tbl[6]  = '{32, 24, 10, 31, 1'b1, 1'b1, 32, 24, 1'b0, 1'b1, 48};
        tbl[7]  = '{32, 24, -1, 0, 1'b1, 1'b1, 32, 24, 1'b0, 1'b1, 48};
        tbl[8]  = '{32, 24, -1, 0, 1'b1, 1'b1, 32, 24, 1'b1, 1'b1, 48};
        tbl[9]  = '{32, 24, -1, 0, 1'b0, 1'b1, 32, 24, 1'b0, 1'b1, 48};
        tbl[10] = '{32, 24, -1, 0, 1'b1, 1'b0, 32, 24, 1'b0, 1'b0, 0};
        tbl[11] = '{32, 24, -1, 0, 1'b1, 1'b1, 32, 24, 1'b0, 1'b0, 48};
        tbl[12] = '{32, 24, -1, 0, 1'b1, 1'b1, 32, 24, 1'b1, 1'b0, 48};
        tbl[13] = '{32, 0,  -1, 0, 1'b1, 1'b1, 0,  0,  1'b0, 1'b0, 0};
        tbl[14] = '{32, 24, -1, 0, 1'b1, 1'b1, 32, 24, 1'b0, 1'b0, 48};

        for (int i = 0; i < 3; i++) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();
        tick();
        enable = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        boundary(fd, w, h, lk, se, nwr);
        chk("initial_frame_done", int'(fd), 0);
        chk("initial_writes", nwr, 0);

        for (int i = 0; i < 15; i++) begin
            drive_active(tbl[i].w, tbl[i].h, tbl[i].sl, tbl[i].slen, tbl[i].en_mid, -1, -1);
            boundary(fd, w, h, lk, se, nwr);
            chk_frame($sformatf("f%0d", i), fd, w, h, lk, se, nwr, tbl[i]);
        end

        // randomized geometry; frames 1 and 2 repeat frame 0 so lock is exercised
        pw = 32; ph = 24; pok = 1'b1;
        rw = 1; rh = 1;
        for (int k = 0; k < 4; k++) begin
            int cols, rows;
            if (k == 0 || k == 3) begin
                rw = $urandom_range(90, 1);
                rh = $urandom_range(60, 1);
            end
            drive_active(rw, rh, -1, 0, 1'b1, -1, -1);
            boundary(fd, w, h, lk, se, nwr);
            cols = (rw + DEC - 1) / DEC;
            rows = (rh + DEC - 1) / DEC;
            if (cols > STRIDE) cols = STRIDE;
            if (rows > ROWS) rows = ROWS;
            e = '{rw, rh, -1, 0, 1'b1, 1'b1, rw, rh,
                  pok && (rw == pw) && (rh == ph), 1'b0, cols * rows};
            chk_frame($sformatf("rnd%0d", k), fd, w, h, lk, se, nwr, e);
            pw = rw; ph = rh; pok = 1'b1;
        end

        // mid-line reset, then capture only after the next boundary
        drive_active(32, 24, -1, 0, 1'b1, 9, 13);
        boundary(fd, w, h, lk, se, nwr);
        chk("post_reset_frame_done", int'(fd), 0);
        chk("post_reset_width", w, 0);
        drive_active(32, 24, -1, 0, 1'b1, -1, -1);
        boundary(fd, w, h, lk, se, nwr);
        e = '{32, 24, -1, 0, 1'b1, 1'b1, 32, 24, 1'b0, 1'b0, 48};
        chk_frame("resume", fd, w, h, lk, se, nwr, e);

        for (int i = 0; i < 4; i++) tick();
        chk("pending_writes", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
